// File: rtl/dcache_pkg.sv
// Shared types and address-field width helpers for the direct-mapped data cache.
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  function automatic int off_w(input int wpl);
    return $clog2(wpl);
  endfunction

  // Word counter keeps at least one bit so a single-word line still has a legal vector.
  function automatic int cnt_w(input int wpl);
    return (wpl > 1) ? $clog2(wpl) : 1;
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int aw, input int sets, input int wpl);
    return aw - 2 - off_w(wpl) - idx_w(sets);
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// CPU-side access port and backing-memory handshake of the data cache.
interface data_cache_if #(parameter int AW = 32);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [3:0]    byteen;
  logic          flush;
  logic [31:0]   rdata;
  logic          stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_byteen;
  logic [31:0]   mem_rdata;
  logic          mem_ack;

  modport slave (
    input  req, we, addr, wdata, byteen, flush, mem_rdata, mem_ack,
    output rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_byteen
  );

  modport master (
    output req, we, addr, wdata, byteen, flush, mem_rdata, mem_ack,
    input  rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_byteen
  );
endinterface

// File: rtl/dcache_store.sv
// Tag, valid and data arrays: combinational read, one byte-enabled word write port.
module dcache_store
  import dcache_pkg::*;
#(
  parameter int SETS = 16,
  parameter int WPL  = 4,
  parameter int AW   = 32,
  localparam int CNT_W = cnt_w(WPL),
  localparam int IDX_W = idx_w(SETS),
  localparam int TAG_W = tag_w(AW, SETS, WPL)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [CNT_W-1:0] rd_off,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [CNT_W-1:0] wr_off,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_be,
  input  logic             tag_wr,
  input  logic [IDX_W-1:0] tag_idx,
  input  logic [TAG_W-1:0] tag_val,
  input  logic             inv_en,
  input  logic [IDX_W-1:0] inv_idx,
  input  logic             clr_all
);
  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];
  logic [31:0]      data [SETS][WPL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (clr_all) begin
      valid <= '0;
    end else begin
      if (inv_en) valid[inv_idx] <= 1'b0;
      if (tag_wr) valid[tag_idx] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until their valid bit is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (tag_wr) tags[tag_idx] <= tag_val;
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) data[wr_idx][wr_off][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[rd_idx][rd_off];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with a valid/ack memory port.
module data_cache
  import dcache_pkg::*;
#(
  parameter int SETS = 16,
  parameter int WPL  = 4,
  parameter int AW   = 32
) (
  input logic        clk,
  input logic        rst_n,
  data_cache_if.slave bus
);
  localparam int OFF_W = off_w(WPL);
  localparam int CNT_W = cnt_w(WPL);
  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(AW, SETS, WPL);

  function automatic logic [CNT_W-1:0] f_off(input logic [AW-1:0] a);
    return CNT_W'((a >> 2) & AW'(WPL - 1));
  endfunction

  function automatic logic [IDX_W-1:0] f_idx(input logic [AW-1:0] a);
    return IDX_W'((a >> (2 + OFF_W)) & AW'(SETS - 1));
  endfunction

  function automatic logic [TAG_W-1:0] f_tag(input logic [AW-1:0] a);
    return TAG_W'(a >> (2 + OFF_W + IDX_W));
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             wdone;
  logic             mreq, mwe;
  logic [AW-1:0]    maddr;
  logic [31:0]      mwdata;
  logic [3:0]       mbe;
  logic             last;
  logic             hit;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;
  logic             wr_en, tag_wr, inv_en, clr_all;
  logic [IDX_W-1:0] wr_idx;
  logic [CNT_W-1:0] wr_off;
  logic [31:0]      wr_data;
  logic [3:0]       wr_be;
  logic [AW-1:0]    line_base, line_cur;

  dcache_store #(.SETS(SETS), .WPL(WPL), .AW(AW)) u_store (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (f_idx(bus.addr)),
    .rd_off   (f_off(bus.addr)),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_off   (wr_off),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .tag_wr   (tag_wr),
    .tag_idx  (f_idx(maddr)),
    .tag_val  (f_tag(maddr)),
    .inv_en   (inv_en),
    .inv_idx  (f_idx(bus.addr)),
    .clr_all  (clr_all)
  );

  assign hit       = rd_valid && (rd_tag == f_tag(bus.addr));
  assign last      = (cnt == CNT_W'(WPL - 1));
  assign cnt_nxt   = cnt + CNT_W'(1);
  assign line_base = bus.addr & ~AW'(4 * WPL - 1);
  assign line_cur  = maddr & ~AW'(4 * WPL - 1);

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = f_idx(bus.addr);
    wr_off  = f_off(bus.addr);
    wr_data = bus.wdata;
    wr_be   = bus.byteen;
    if (state == REFILL && bus.mem_ack) begin
      wr_en   = 1'b1;
      wr_idx  = f_idx(maddr);
      wr_off  = cnt;
      wr_data = bus.mem_rdata;
      wr_be   = 4'hf;
    end else if (state == WRITE && bus.mem_ack && hit) begin
      wr_en = 1'b1;
    end
  end

  assign tag_wr  = (state == REFILL) && bus.mem_ack && last;
  assign inv_en  = (state == IDLE) && bus.req && !bus.we && !hit;
  assign clr_all = (state == IDLE) && bus.flush && !bus.req;

  // wdone marks the held store as retired so the cycle after its ack neither stalls nor re-issues.
  assign bus.stall = (state != IDLE) || (bus.req && ((bus.we && !wdone) || (!bus.we && !hit)));
  assign bus.rdata = (bus.req && !bus.we && hit) ? rd_data : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      wdone  <= 1'b0;
      mreq   <= 1'b0;
      mwe    <= 1'b0;
      maddr  <= '0;
      mwdata <= '0;
      mbe    <= '0;
    end else begin
      wdone <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req && bus.we && !wdone) begin
            state  <= WRITE;
            mreq   <= 1'b1;
            mwe    <= 1'b1;
            maddr  <= bus.addr & ~AW'(3);
            mwdata <= bus.wdata;
            mbe    <= bus.byteen;
          end else if (bus.req && !bus.we && !hit) begin
            state <= REFILL;
            cnt   <= '0;
            mreq  <= 1'b1;
            mwe   <= 1'b0;
            maddr <= line_base;
          end
        end
        REFILL: begin
          if (bus.mem_ack) begin
            cnt <= last ? '0 : cnt_nxt;
            if (last) begin
              state <= IDLE;
              mreq  <= 1'b0;
            end else begin
              maddr <= line_cur | (AW'(cnt_nxt) << 2);
            end
          end
        end
        WRITE: begin
          if (bus.mem_ack) begin
            state <= IDLE;
            wdone <= 1'b1;
            mreq  <= 1'b0;
            mwe   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req    = mreq;
  assign bus.mem_we     = mwe;
  assign bus.mem_addr   = maddr;
  assign bus.mem_wdata  = mwdata;
  assign bus.mem_byteen = mbe;

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: backing-memory model with 2-cycle ack and request/load scoreboards.
module tb_data_cache;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_cache_if #(.AW(AW)) bus ();

  data_cache #(.SETS(16), .WPL(4), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mreq_t;

  int          total = 0;
  int          bad = 0;
  int          nmem = 0;
  mreq_t       mq[$];
  logic [31:0] dq[$];
  logic [31:0] shadow [logic [31:0]];

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (shadow.exists(a)) return shadow[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_refill(input logic [31:0] a);
    logic [31:0] base;
    base = a & ~32'hF;
    for (int i = 0; i < 4; i++) mq.push_back('{base + 32'(4 * i), 1'b0, 32'h0, 4'h0});
  endtask

  task automatic load(input string tag, input logic [31:0] a, input logic [31:0] exp,
                      input int exp_stall);
    int n;
    n = 0;
    dq.push_back(exp);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = a;
    forever begin
      @(negedge clk);
      if (!bus.stall || n >= 200) break;
      n++;
    end
    chk({tag, "_stall"}, 32'(n), 32'(exp_stall));
    chk({tag, "_rdata"}, bus.rdata, dq.pop_front());
    @(posedge clk); #1;
    bus.req = 1'b0;
  endtask

  task automatic store(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be);
    int n;
    n = 0;
    mq.push_back('{a & ~32'h3, 1'b1, d, be});
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d; bus.byteen = be;
    forever begin
      @(negedge clk);
      if (!bus.stall || n >= 200) break;
      n++;
    end
    chk({tag, "_stall"}, 32'(n), 32'd3);
    @(posedge clk); #1;
    bus.req = 1'b0; bus.we = 1'b0;
  endtask

  // Backing memory: acks on the second cycle of each request and checks it against the queue.
  initial begin
    int    w;
    mreq_t e;
    logic [31:0] old;
    w = 0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      if (!rst_n || !bus.mem_req) begin
        w = 0;
      end else begin
        w++;
        if (w == 2) begin
          w = 0;
          bus.mem_ack = 1'b1;
          nmem++;
          chk("mreq_expected", 32'(mq.size() > 0), 32'd1);
          if (mq.size() > 0) begin
            e = mq.pop_front();
            chk("mreq_addr", bus.mem_addr, e.addr);
            chk("mreq_we", 32'(bus.mem_we), 32'(e.we));
            if (e.we) begin
              chk("mreq_wdata", bus.mem_wdata, e.wdata);
              chk("mreq_be", 32'(bus.mem_byteen), 32'(e.be));
            end
          end
          if (bus.mem_we) begin
            old = memval(bus.mem_addr);
            for (int b = 0; b < 4; b++)
              if (bus.mem_byteen[b]) old[8*b +: 8] = bus.mem_wdata[8*b +: 8];
            shadow[bus.mem_addr] = old;
          end else begin
            bus.mem_rdata = memval(bus.mem_addr);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int m0;
    logic [31:0] old;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    bus.byteen = '0; bus.flush = 1'b0;
    shadow[32'h100] = 32'hDEADBEEF;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_mem_be", 32'(bus.mem_byteen), 32'h0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_rdata", bus.rdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    m0 = nmem;
    expect_refill(32'h100);
    load("t1_miss", 32'h100, 32'hDEADBEEF, 9);
    chk("t1_nmem", 32'(nmem - m0), 32'd4);

    m0 = nmem;
    load("t2_hit", 32'h104, 32'h5A5A_0104, 0);
    chk("t2_nmem", 32'(nmem - m0), 32'd0);

    m0 = nmem;
    store("t3_store", 32'h100, 32'h0000_00AA, 4'b0001);
    load("t3_load", 32'h100, 32'hDEADBEAA, 0);
    chk("t3_nmem", 32'(nmem - m0), 32'd1);

    store("t4_store_miss", 32'h900, 32'hCAFE_F00D, 4'b1111);
    load("t4_still_valid", 32'h100, 32'hDEADBEAA, 0);
    expect_refill(32'h900);
    load("t4_refill", 32'h900, 32'hCAFE_F00D, 9);

    expect_refill(32'h100);
    load("t5_a", 32'h100, 32'hDEADBEAA, 9);
    expect_refill(32'h500);
    load("t5_evict", 32'h500, 32'h5A5A_0500, 9);
    expect_refill(32'h100);
    load("t5_remiss", 32'h100, 32'hDEADBEAA, 9);

    expect_refill(32'h1FC);
    load("top_idx_miss", 32'h1FC, 32'h5A5A_01FC, 9);
    load("top_idx_hit", 32'h1F0, 32'h5A5A_01F0, 0);
    old = memval(32'h1F4);
    store("top_idx_store", 32'h1F4, 32'h1200_0000, 4'b1000);
    load("top_idx_merge", 32'h1F4, {8'h12, old[23:0]}, 0);

    // Abort a refill of 0x500 partway through its second word.
    m0 = nmem;
    expect_refill(32'h500);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h500;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.req = 1'b0;
    #1;
    chk("t6_memreq_drop", 32'(bus.mem_req), 32'd0);
    chk("t6_stall_drop", 32'(bus.stall), 32'd0);
    chk("t6_acks_before", 32'(nmem - m0), 32'd1);
    mq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_refill(32'h500);
    load("t6_refill", 32'h500, 32'h5A5A_0500, 9);

    bus.flush = 1'b1;
    load("t6_flush_req", 32'h500, 32'h5A5A_0500, 0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    expect_refill(32'h500);
    load("t6_after_flush", 32'h500, 32'h5A5A_0500, 9);

    repeat (4) @(posedge clk);
    #1;
    chk("mq_drained", 32'(mq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
